multicycle_seq: RTL
===================

# multicycle_seq

Multi-cycle sequencer for the rvseed core. Turns the shared fetch/decode/ALU/register-file datapath into a fetch, execute, memory, writeback machine with req/gnt/rvalid handshakes on separate instruction and data buses. Takes the combinational decode flags (branch, jump, jalr, zero, reg_wen, load/store) and generates the per-cycle enables: instruction-register load, PC update/select, gated register write, data-bus request. Also counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, 255: bus wait limit in cycles (used only with the timeout macro); counter width `$clog2(TIMEOUT_CYCLES+1)`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `halt_req` in 1: hold before the next fetch.
- `branch`, `jump`, `jalr`, `zero`, `reg_wen` in 1 each: decode flags, valid in EXEC.
- `inst_load`, `inst_store` in 1 each: decode flags, valid in EXEC.
- `ibus_req` out 1: fetch request.
- `ibus_gnt`, `ibus_rvalid` in 1 each: fetch grant and read data valid.
- `dbus_req`, `dbus_we` out 1 each: data request and write strobe.
- `dbus_gnt`, `dbus_rvalid` in 1 each: data grant, and read-data/write-ack valid.
- `ir_wen` out 1: load the instruction register with ibus rdata.
- `ld_wen` out 1: latch dbus rdata into the load-data register.
- `pc_wen` out 1: update the PC.
- `pc_sel` out 2: 0 = PC+4, 1 = PC+imm (branch/jal), 2 = (rs1+imm)&~1 (jalr).
- `rf_wen` out 1: register-file write enable.
- `wb_sel` out 1: 0 = ALU result, 1 = load data.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out `CPU_WIDTH`: count of retired instructions.
- `halted` out 1: high while parked by `halt_req`.
- `bus_err` out 1: sticky bus-timeout flag.

## Operation
- States: F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, ERR.
- Reset (`rst_n`=0 at an edge):
  - State becomes F_REQ.
  - All outputs 0, `instret`=0, timeout counter 0, `bus_err`=0.
- F_REQ:
  - If `halt_req`=1: `ibus_req`=0, `halted`=1, remain in F_REQ.
  - Otherwise: `ibus_req`=1, held until `ibus_gnt`. On gnt, go to F_WAIT.
- F_WAIT: wait for `ibus_rvalid`. When it arrives, pulse `ir_wen` and go to EXEC.
- EXEC: one cycle for decode/ALU settling.
  - `inst_load` or `inst_store` → M_REQ.
  - Otherwise → WB.
- M_REQ:
  - `dbus_req`=1, with `dbus_we`=`inst_store` latched in EXEC. Held until `dbus_gnt`, then go to M_WAIT.
  - `dbus_we` is stable while `dbus_req` is high.
- M_WAIT: wait for `dbus_rvalid`, then go to WB. For a load, `ld_wen`=1 in that cycle.
- WB: one cycle.
  - `pc_wen`=1, `retire`=1, `instret`+=1 (wraps from 2^32-1 to 0).
  - `rf_wen`=`reg_wen` & ~`inst_store`.
  - `wb_sel`=`inst_load`.
  - `pc_sel` = 2 if `jalr`; else 1 if `jump` | (`branch` & `zero`); else 0.
  - Then go to F_REQ.
- Decode flags are sampled only in EXEC and WB. They depend only on the instruction register, which is stable from EXEC through WB.
- `rvalid` seen in any state other than F_WAIT/M_WAIT is ignored. This includes a stale response arriving after a mid-transaction reset.
- `gnt` and `rvalid` on the same bus in the same cycle is illegal (rvalid is at least 1 cycle after gnt).
- `halt_req` is checked only in F_REQ. An in-flight instruction always completes through WB.
- ERR: exists only with the timeout macro.
  - All requests and enables 0; `bus_err`=1.
  - Left only by reset.

## Timing
- Minimum latency, with gnt in the same cycle as req and rvalid 1 cycle later:
  - ALU/branch/jump: 4 cycles (F_REQ, F_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- Each extra gnt or rvalid wait cycle adds exactly one cycle.
- All outputs are decoded from the registered state (Moore), except:
  - `ibus_req` also depends on `halt_req`.
  - `ir_wen` and `ld_wen` follow `rvalid` combinationally.
- The first `ibus_req` is asserted in the first cycle after `rst_n` rises, unless `halt_req`=1.

## Configuration
- `RVSEED_BUS_TIMEOUT_EN` defined:
  - The counter clears on entry to F_REQ, F_WAIT, M_REQ and M_WAIT, and increments each cycle the state is unchanged.
  - When it reaches `TIMEOUT_CYCLES` while still waiting, the next state is ERR.
  - The counter is frozen in F_REQ while halted.
- `RVSEED_BUS_TIMEOUT_EN` undefined:
  - Waits are unbounded, `bus_err` is tied to 0, ERR is unreachable and no counter is built.

## Test plan
- ADD, gnt immediate, rvalid +1 → `ir_wen` cycle 2, `rf_wen`=1/`pc_sel`=0/`retire` cycle 4, `instret`=1.
- LW with dbus gnt delayed 3 cycles, rvalid +2 → `dbus_we`=0, `ld_wen` then WB `wb_sel`=1 `rf_wen`=1, total 10 cycles. SW → `dbus_we`=1, `rf_wen`=0.
- BEQ with `zero`=1 → `pc_sel`=1; with `zero`=0 → `pc_sel`=0. JALR → `pc_sel`=2, `rf_wen`=1.
- `halt_req`=1 during EXEC of an instruction → that instruction retires, then `ibus_req`=0 and `halted`=1. Release → fetch resumes the next cycle.
- Reset asserted in M_WAIT, then a stale `dbus_rvalid` after release → ignored; `instret`=0; state F_REQ.
- With the macro and `TIMEOUT_CYCLES`=8, `ibus_gnt` never asserted → ERR after 8 waiting cycles, `bus_err`=1, `ibus_req`=0 until reset. Without the macro → waits indefinitely, `bus_err`=0.

Source files
------------

// File: rtl/multicycle_seq.sv
// multicycle_seq: fetch/exec/mem/writeback sequencer for the rvseed core.
// Latency: 4 cycles for ALU/branch/jump and 6 for load/store with zero-wait buses; each gnt/rvalid wait cycle adds one.
// Backpressure: req held until gnt, then rvalid awaited; halt_req parks in F_REQ. Optional macro RVSEED_BUS_TIMEOUT_EN adds a bus timeout to ERR.
module multicycle_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CPU_WIDTH      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_halt_req,
    input  logic                 i_branch,
    input  logic                 i_jump,
    input  logic                 i_jalr,
    input  logic                 i_zero,
    input  logic                 i_reg_wen,
    input  logic                 i_inst_load,
    input  logic                 i_inst_store,
    output logic                 o_ibus_req,
    input  logic                 i_ibus_gnt,
    input  logic                 i_ibus_rvalid,
    output logic                 o_dbus_req,
    output logic                 o_dbus_we,
    input  logic                 i_dbus_gnt,
    input  logic                 i_dbus_rvalid,
    output logic                 o_ir_wen,
    output logic                 o_ld_wen,
    output logic                 o_pc_wen,
    output logic [1:0]           o_pc_sel,
    output logic                 o_rf_wen,
    output logic                 o_wb_sel,
    output logic                 o_retire,
    output logic [CPU_WIDTH-1:0] o_instret,
    output logic                 o_halted,
    output logic                 o_bus_err
);

    typedef enum logic [2:0] {
        S_F_REQ,
        S_F_WAIT,
        S_EXEC,
        S_M_REQ,
        S_M_WAIT,
        S_WB,
        S_ERR
    } state_t;

    state_t                r_state;
    logic                  r_store;   // memory op is a store, captured in EXEC
    logic                  r_load;    // memory op is a load, captured in EXEC
    logic [CPU_WIDTH-1:0]  r_instret;

`ifdef RVSEED_BUS_TIMEOUT_EN
    localparam int                 TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_waiting;
    logic             w_progress;

    // A wait state is any bus handshake state; halted F_REQ is parked, not waiting.
    always_comb begin
        w_waiting  = ((r_state == S_F_REQ) && !i_halt_req) ||
                     (r_state == S_F_WAIT) || (r_state == S_M_REQ) ||
                     (r_state == S_M_WAIT);
        w_progress = ((r_state == S_F_REQ)  && i_ibus_gnt)    ||
                     ((r_state == S_F_WAIT) && i_ibus_rvalid) ||
                     ((r_state == S_M_REQ)  && i_dbus_gnt)    ||
                     ((r_state == S_M_WAIT) && i_dbus_rvalid);
    end
`endif

    // Sequencer state, latched memory-op kind, retire counter and optional timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_F_REQ;
            r_store   <= 1'b0;
            r_load    <= 1'b0;
            r_instret <= '0;
`ifdef RVSEED_BUS_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_F_REQ:  if (!i_halt_req && i_ibus_gnt) r_state <= S_F_WAIT;
                S_F_WAIT: if (i_ibus_rvalid) r_state <= S_EXEC;
                S_EXEC: begin
                    r_store <= i_inst_store;
                    r_load  <= i_inst_load;
                    r_state <= (i_inst_load || i_inst_store) ? S_M_REQ : S_WB;
                end
                S_M_REQ:  if (i_dbus_gnt) r_state <= S_M_WAIT;
                S_M_WAIT: if (i_dbus_rvalid) r_state <= S_WB;
                S_WB: begin
                    r_instret <= r_instret + CPU_WIDTH'(1);
                    r_state   <= S_F_REQ;
                end
                default:  r_state <= r_state;  // ERR is left only by reset
            endcase
`ifdef RVSEED_BUS_TIMEOUT_EN
            // Later assignment to r_state overrides the case above on expiry.
            if (w_waiting) begin
                if (w_progress) begin
                    r_tmo_cnt <= '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    r_state <= S_ERR;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
            end else if (r_state != S_F_REQ) begin
                r_tmo_cnt <= '0;
            end
`endif
        end
    end

    // Outputs decode the registered state; fetch request/halt also see halt_req,
    // and the register-load strobes follow rvalid directly.
    always_comb begin
        o_ibus_req = i_rst_n && (r_state == S_F_REQ) && !i_halt_req;
        o_halted   = i_rst_n && (r_state == S_F_REQ) && i_halt_req;
        o_ir_wen   = (r_state == S_F_WAIT) && i_ibus_rvalid;
        o_dbus_req = (r_state == S_M_REQ);
        o_dbus_we  = (r_state == S_M_REQ) && r_store;
        o_ld_wen   = (r_state == S_M_WAIT) && i_dbus_rvalid && r_load;
        o_pc_wen   = (r_state == S_WB);
        o_retire   = (r_state == S_WB);
        o_rf_wen   = (r_state == S_WB) && i_reg_wen && !i_inst_store;
        o_wb_sel   = (r_state == S_WB) && i_inst_load;
        o_pc_sel   = 2'd0;
        if (r_state == S_WB) begin
            if (i_jalr)                             o_pc_sel = 2'd2;
            else if (i_jump || (i_branch && i_zero)) o_pc_sel = 2'd1;
        end
        o_instret  = r_instret;
`ifdef RVSEED_BUS_TIMEOUT_EN
        o_bus_err  = (r_state == S_ERR);
`else
        o_bus_err  = 1'b0;
`endif
    end

endmodule
